// File: rtl/prog_ctr_fetch_pkg.sv
// prog_ctr_fetch_pkg
// Shared definitions for the program-counter / fetch stage. The default
// address and offset widths live here so the instruction ROM and the branch
// lookup table are sized from the same constants as the program counter.
package prog_ctr_fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // Default program counter width (instruction ROM address width)
  localparam int PC_W_DEF  = 12;
  // Default width of the signed PC-relative branch offset
  localparam int OFF_W_DEF = 8;

endpackage

// File: rtl/prog_ctr_fetch.sv
// prog_ctr_fetch
// Program counter and fetch sequencer. Produces one instruction ROM address
// per cycle and sequences a program through IDLE -> RUN -> DONE.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   begin a program (honoured in IDLE or DONE only)
//   stall     in   hold the PC, nothing retires this cycle
//   halt      in   the instruction at prog_ctr is a halt
//   abs_jump  in   load target into the PC
//   rel_en    in   add the signed offset to the PC
//   target    in   [D-1:0]     absolute jump address
//   offset    in   [OFF_W-1:0] signed relative displacement
//   prog_ctr  out  [D-1:0]     registered ROM address
//   running   out  high while in RUN
//   done      out  high while in DONE
//   retired   out  [CNT_W-1:0] saturating retired-instruction count
module prog_ctr_fetch
  import prog_ctr_fetch_pkg::*;
#(
  parameter int D          = PC_W_DEF,
  parameter int START_ADDR = 0,
  parameter int OFF_W      = OFF_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             abs_jump,
  input  logic             rel_en,
  input  logic [D-1:0]     target,
  input  logic [OFF_W-1:0] offset,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  localparam logic [D-1:0]     START_PC = D'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  fetch_state_e     state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] retired_inc_s;
  logic [D-1:0]     rel_ext_s;

  // Sign-extend the offset to PC width; the add then wraps modulo 2^D.
  assign rel_ext_s = D'($signed(offset));

  // Saturating increment of the retired counter
  always_comb begin
    if (retired_q == CNT_MAX) begin
      retired_inc_s = retired_q;
    end else begin
      retired_inc_s = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state, next-PC priority mux and status flag decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        pc_d      = START_PC;
        retired_d = {CNT_W{1'b0}};
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // stall > halt > abs_jump > rel_en > sequential
        if (stall) begin
          state_d = ST_RUN;
        end else if (halt) begin
          // PC stays on the halt address; the halt itself retires
          state_d   = ST_DONE;
          retired_d = retired_inc_s;
        end else if (abs_jump) begin
          pc_d      = target;
          retired_d = retired_inc_s;
        end else if (rel_en) begin
          pc_d      = pc_q + rel_ext_s;
          retired_d = retired_inc_s;
        end else begin
          pc_d      = pc_q + {{(D-1){1'b0}}, 1'b1};
          retired_d = retired_inc_s;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          pc_d      = START_PC;
          retired_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pc_d      = START_PC;
        retired_d = {CNT_W{1'b0}};
      end
    endcase

    // Flags are registered from the next state so they line up with it
    if (state_d == ST_RUN) begin
      running_d = 1'b1;
    end else begin
      running_d = 1'b0;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // State, PC, counter and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_PC;
      retired_q <= {CNT_W{1'b0}};
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign prog_ctr = pc_q;
  assign running  = running_q;
  assign done     = done_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_prog_ctr_fetch.sv
// tb_prog_ctr_fetch
// Self-checking bench for prog_ctr_fetch: directed scenarios plus a
// randomized run, all compared against an integer-arithmetic program model.
module tb_prog_ctr_fetch;

  localparam int D     = 12;
  localparam int OFF_W = 8;
  localparam int CNT_W = 16;
  localparam int PC_MOD  = 4096;
  localparam int CNT_SAT = 65535;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             halt = 1'b0;
  logic             abs_jump = 1'b0;
  logic             rel_en = 1'b0;
  logic [D-1:0]     target = '0;
  logic [OFF_W-1:0] offset = '0;
  logic [D-1:0]     prog_ctr;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad = 0;

  // Model: mode 0 = idle, 1 = executing, 2 = finished
  int m_mode = 0;
  int m_pc = 0;
  int m_ret = 0;

  prog_ctr_fetch #(.D(D), .START_ADDR(0), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .abs_jump(abs_jump), .rel_en(rel_en), .target(target), .offset(offset),
    .prog_ctr(prog_ctr), .running(running), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  // What one clock edge does to the program, given the current inputs
  function automatic void model_edge();
    int off;
    off = $signed(offset);
    if (reset) begin
      m_mode = 0; m_pc = 0; m_ret = 0;
    end else if (m_mode == 1) begin
      if (!stall) begin
        m_ret = (m_ret >= CNT_SAT) ? CNT_SAT : m_ret + 1;
        if (halt)          m_mode = 2;
        else if (abs_jump) m_pc = int'(target);
        else if (rel_en)   m_pc = (m_pc + off + PC_MOD) % PC_MOD;
        else               m_pc = (m_pc + 1) % PC_MOD;
      end
    end else if (start) begin
      m_mode = 1; m_pc = 0; m_ret = 0;
    end else if (m_mode == 0) begin
      m_pc = 0; m_ret = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    abs_jump = 1'b0; rel_en = 1'b0; target = '0; offset = '0;
  endtask

  task automatic restart();
    idle_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    total++; if ({running, done} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {running, done}); end
    total++; if (prog_ctr !== 12'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", prog_ctr); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    tick();
    total++; if (prog_ctr !== 12'd0 || running !== 1'b0) begin bad++; $display("FAIL idle_hold got pc=%0d run=%b exp pc=0 run=0", prog_ctr, running); end
  endtask

  task automatic test_sequential();
    start = 1'b1; tick(); start = 1'b0;
    total++; if (prog_ctr !== 12'd0 || running !== 1'b1 || retired !== 16'd0) begin bad++; $display("FAIL start got pc=%0d run=%b ret=%0d exp 0 1 0", prog_ctr, running, retired); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (prog_ctr !== D'(i)) begin bad++; $display("FAIL seq_pc got=%0d exp=%0d", prog_ctr, i); end
    end
    total++; if (retired !== 16'd5 || running !== 1'b1) begin bad++; $display("FAIL seq_retired got ret=%0d run=%b exp 5 1", retired, running); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 5; i++) tick();
    total++; if (prog_ctr !== 12'd10) begin bad++; $display("FAIL branch_setup got=%0d exp=10", prog_ctr); end
    abs_jump = 1'b1; target = 12'd200; rel_en = 1'b1; offset = 8'hFD;
    tick();
    total++; if (prog_ctr !== 12'd200) begin bad++; $display("FAIL abs_wins got=%0d exp=200", prog_ctr); end
    abs_jump = 1'b0;
    tick();
    rel_en = 1'b0;
    total++; if (prog_ctr !== 12'd197) begin bad++; $display("FAIL rel_back got=%0d exp=197", prog_ctr); end
    total++; if (retired !== 16'd12) begin bad++; $display("FAIL branch_retired got=%0d exp=12", retired); end
  endtask

  task automatic test_stall_halt();
    restart();
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1; halt = 1'b1; abs_jump = 1'b1; target = 12'd99;
    tick(); tick();
    total++; if (prog_ctr !== 12'd4 || retired !== 16'd4 || running !== 1'b1) begin bad++; $display("FAIL stall_hold got pc=%0d ret=%0d run=%b exp 4 4 1", prog_ctr, retired, running); end
    stall = 1'b0; abs_jump = 1'b0;
    tick();
    total++; if (done !== 1'b1 || running !== 1'b0 || prog_ctr !== 12'd4 || retired !== 16'd5) begin bad++; $display("FAIL halt got done=%b run=%b pc=%0d ret=%0d exp 1 0 4 5", done, running, prog_ctr, retired); end
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      abs_jump = 1'($urandom); rel_en = 1'($urandom); stall = 1'($urandom); offset = 8'($urandom);
      tick();
    end
    total++; if (done !== 1'b1 || prog_ctr !== 12'd4 || retired !== 16'd5) begin bad++; $display("FAIL done_hold got done=%b pc=%0d ret=%0d exp 1 4 5", done, prog_ctr, retired); end
  endtask

  task automatic test_wrap();
    restart();
    abs_jump = 1'b1; target = 12'd4095; tick(); abs_jump = 1'b0;
    tick();
    total++; if (prog_ctr !== 12'd0) begin bad++; $display("FAIL wrap_up got=%0d exp=0", prog_ctr); end
    abs_jump = 1'b1; target = 12'd2; tick(); abs_jump = 1'b0;
    rel_en = 1'b1; offset = 8'hFB; tick(); rel_en = 1'b0;
    total++; if (prog_ctr !== 12'd4093) begin bad++; $display("FAIL wrap_down got=%0d exp=4093", prog_ctr); end
  endtask

  task automatic test_reset_mid_run();
    restart();
    abs_jump = 1'b1; target = 12'd37; tick(); abs_jump = 1'b0;
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    total++; if ({running, done} !== 2'b00 || prog_ctr !== 12'd0 || retired !== 16'd0) begin bad++; $display("FAIL mid_reset got run=%b done=%b pc=%0d ret=%0d exp 0 0 0 0", running, done, prog_ctr, retired); end
    start = 1'b1; tick(); start = 1'b0; tick();
    total++; if (prog_ctr !== 12'd1 || running !== 1'b1) begin bad++; $display("FAIL reset_restart got pc=%0d run=%b exp 1 1", prog_ctr, running); end
  endtask

  task automatic test_back_to_back();
    restart();
    tick(); tick();
    halt = 1'b1; tick(); halt = 1'b0;
    total++; if (done !== 1'b1 || prog_ctr !== 12'd2) begin bad++; $display("FAIL b2b_halt got done=%b pc=%0d exp 1 2", done, prog_ctr); end
    start = 1'b1; tick();
    total++; if (done !== 1'b0 || running !== 1'b1 || prog_ctr !== 12'd0 || retired !== 16'd0) begin bad++; $display("FAIL done_restart got done=%b run=%b pc=%0d ret=%0d exp 0 1 0 0", done, running, prog_ctr, retired); end
    tick(); tick(); tick();
    start = 1'b0;
    total++; if (prog_ctr !== 12'd3 || retired !== 16'd3) begin bad++; $display("FAIL start_in_run got pc=%0d ret=%0d exp 3 3", prog_ctr, retired); end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      halt = ($urandom_range(0, 19) == 0);
      abs_jump = ($urandom_range(0, 3) == 0);
      rel_en = ($urandom_range(0, 2) == 0);
      target = D'($urandom);
      offset = OFF_W'($urandom);
      tick();
      total++;
      if (prog_ctr !== D'(m_pc) || retired !== CNT_W'(m_ret) || running !== (m_mode == 1) || done !== (m_mode == 2)) begin
        bad++;
        $display("FAIL random[%0d] got pc=%0d ret=%0d run=%b done=%b exp pc=%0d ret=%0d mode=%0d", i, prog_ctr, retired, running, done, m_pc, m_ret, m_mode);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    restart();
    for (int i = 0; i < CNT_SAT + 4; i++) tick();
    total++; if (retired !== 16'hFFFF || prog_ctr !== D'(m_pc)) begin bad++; $display("FAIL saturate got ret=%0d pc=%0d exp ret=65535 pc=%0d", retired, prog_ctr, m_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_halt();
    test_wrap();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_ctr_fetch.md
Name: prog_ctr_fetch

Overview:
- Program-counter and fetch-sequencing stage that drives the address input of the 9-bit instruction ROM, one address per cycle.
- Controls program start, sequential advance, absolute and PC-relative branches, stalls and halt.
- Raises a done flag that the top level and testbench use as the end-of-program handshake.
- Keeps a retired-instruction counter for bench checks.

Parameters:
- D, 12, program counter width; must match the instruction ROM address width.
- START_ADDR, 0, address loaded on every program start.
- OFF_W, 8, width of the signed PC-relative offset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
- start  input  1  begin a program; acted on only in IDLE or DONE.
- stall  input  1  hold the PC this cycle; no instruction retires.
- halt  input  1  decoded halt for the instruction at prog_ctr.
- abs_jump  input  1  load target into the PC.
- rel_en  input  1  add offset to the PC (branch taken).
- target  input  D  absolute jump address, from the branch lookup table.
- offset  input  OFF_W  signed two's-complement relative displacement.
- prog_ctr  output  D  address to the instruction ROM; registered.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- retired  output  CNT_W  count of retired instructions for the current program.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - prog_ctr=START_ADDR, running=0, done=0, retired=0.
  - Reset wins over every other input, including mid-RUN.
- IDLE:
  - prog_ctr is held at START_ADDR.
  - start=1 moves to RUN on the next edge, with prog_ctr=START_ADDR and retired=0.
- RUN: evaluated each edge in this strict priority order.
  1. stall=1: PC, retired and state all hold. halt, abs_jump and rel_en are ignored.
  2. halt=1: go to DONE. The PC holds at the halt address. retired increments, because the halt instruction counts.
  3. abs_jump=1: PC<=target; retired+1.
  4. rel_en=1: PC<=PC+sign_ext(offset), modulo 2^D; retired+1.
  5. Otherwise: PC<=PC+1, modulo 2^D; retired+1.
- start while in RUN is ignored.
- abs_jump and rel_en asserted together: abs_jump wins.
- Wrap-around:
  - PC=2^D-1 with a sequential advance gives 0.
  - Negative offsets that go below 0 wrap modulo 2^D.
  - No error flag is raised in either case.
- retired saturates at 2^CNT_W-1 and does not wrap.
- DONE:
  - done=1 and prog_ctr hold until start=1 or reset.
  - start=1 goes to RUN with prog_ctr=START_ADDR, retired=0 and done=0, all on the same edge.
- Outputs running and done are decoded from the state register, so they are glitch-free and valid one edge after each transition.
- Latency: a new prog_ctr is visible on the edge following the control inputs. The ROM is combinational, so mach_code follows in the same cycle.
- Control inputs are don't-care outside RUN, except start.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE) as a 2-bit logic enum;
  - the default D and OFF_W constants, shared with the instruction ROM and the branch lookup table.
- No sub-module: next-PC selection is a single priority mux plus adder inside this block.
- The branch lookup table stays a separate existing-style combinational LUT feeding target.

Test Plan:
- Reset, then start pulse, then 5 free cycles -> prog_ctr sequence 0,1,2,3,4,5; retired=5; running=1.
- At PC=10, abs_jump=1 with target=200 and rel_en=1 with offset=-3 in the same cycle -> PC=200 (abs wins); then next cycle rel_en=1, offset=-3 -> PC=197.
- At PC=4, 2-cycle stall with halt=1 held -> PC stays 4 and retired is unchanged. When stall drops with halt=1 -> done=1, PC=4, retired incremented by 1. Further cycles -> all values hold.
- PC=4095 (D=12) sequential advance -> PC=0. At PC=2, rel_en=1 with offset=-5 -> PC=4093.
- In RUN at PC=37, assert reset for 1 cycle -> the next edge gives IDLE, PC=0, retired=0, done=0. A later start restarts from 0.
- In DONE, start pulse -> done falls and PC=0 on the same edge. A start during RUN leaves PC progression unchanged.
